// File: rtl/router_rx_par.sv
// router_rx_par
// Parallel-lane frame receiver. Beats arrive on rxd qualified by rx_ce,
// with sync marking the first beat of a frame. Each completed frame is
// pushed into a first-word-fall-through FIFO that software drains over a
// small Wishbone-style slave port. Two sticky flags report dropped frames
// (overrun) and frames broken by an early sync (frmerr).

module router_rx_par #(
    parameter int pBitsParallel = 4,
    parameter int pFrameBits    = 128,
    parameter int pFifoDepth    = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,

    input  logic                          cs_i,
    input  logic                          cyc_i,
    input  logic                          stb_i,
    input  logic                          we_i,
    input  logic                          adr_i,
    input  logic [31:0]                   dat_i,
    output logic                          ack_o,
    output logic [pFrameBits-1:0]         dat_o,

    input  logic                          rx_ce,
    input  logic [pBitsParallel-1:0]      rxd,
    input  logic                          sync,
    input  logic                          clear,

    output logic                          overrun,
    output logic                          frmerr,
    output logic                          fifofull,
    output logic                          fifoempty,
    output logic                          irq_o,
    output logic [$clog2(pFifoDepth):0]   fifocnt
);

    // Derived sizes. The beat counter needs at least one bit even when a
    // frame is a single beat wide.
    localparam int pBeats = pFrameBits / pBitsParallel;
    localparam int pCntW  = $clog2(pFifoDepth) + 1;
    localparam int pPtrW  = $clog2(pFifoDepth);
    localparam int pBeatW = (pBeats > 1) ? $clog2(pBeats) : 1;

    localparam logic [pBeatW-1:0] cLastBeat  = pBeatW'(pBeats - 1);
    localparam logic [pBeatW-1:0] cAfterSync = (pBeats > 1) ? pBeatW'(1) : pBeatW'(0);
    localparam logic [pCntW-1:0]  cFullCount = pCntW'(pFifoDepth);

    // ------------------------------------------------------------------
    // Receive-side synchronizer stages
    // ------------------------------------------------------------------
    logic                     r_ce1;
    logic                     r_ce2;
    logic                     r_sync1;
    logic                     r_sync2;
    logic [pBitsParallel-1:0] r_rxd1;
    logic [pBitsParallel-1:0] r_rxd2;

    // ------------------------------------------------------------------
    // Frame assembly state
    // ------------------------------------------------------------------
    logic [pFrameBits-1:0]    r_rxData;
    logic [pBeatW-1:0]        r_cnt;
    logic [pFrameBits-1:0]    w_shift;
    logic                     w_beat;
    logic                     w_syncErr;
    logic                     w_frameDone;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [pFrameBits-1:0]    r_mem [pFifoDepth];
    logic [pPtrW-1:0]         r_wrPtr;
    logic [pPtrW-1:0]         r_rdPtr;
    logic [pCntW-1:0]         r_count;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;
    logic [pFrameBits-1:0]    w_head;

    // ------------------------------------------------------------------
    // Bus side
    // ------------------------------------------------------------------
    logic                     r_ack;
    logic                     w_cs;
    logic                     w_firstClk;
    logic                     w_dataRead;
    logic                     w_statusWrite;
    logic [7:0]               w_cnt8;
    logic [31:0]              w_status32;
    logic [pFrameBits-1:0]    w_statusWide;
    logic                     w_unusedBits;

    // ------------------------------------------------------------------
    // Sticky flags and their set/clear terms
    // ------------------------------------------------------------------
    logic                     r_overrun;
    logic                     r_frmerr;
    logic                     w_overrunSet;
    logic                     w_overrunClr;
    logic                     w_frmerrClr;

    // Two-stage capture of the receive lane inputs; only stage 2 is used.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ce1   <= 1'b0;
            r_ce2   <= 1'b0;
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_rxd1  <= '0;
            r_rxd2  <= '0;
        end else begin
            r_ce1   <= rx_ce;
            r_ce2   <= r_ce1;
            r_sync1 <= sync;
            r_sync2 <= r_sync1;
            r_rxd1  <= rxd;
            r_rxd2  <= r_rxd1;
        end
    end

    // A beat is a stage-2 strobe that is not being flushed by clear.
    assign w_beat      = r_ce2 & ~clear;
    assign w_syncErr   = w_beat & r_sync2 & (r_cnt != '0);
    assign w_frameDone = w_beat & ~w_syncErr & (r_cnt == cLastBeat);

    // New beats enter at the top and move toward bit 0, so the first beat
    // of a frame ends up in the lowest lanes once the frame is complete.
    generate
        if (pBeats > 1) begin : g_shiftMulti
            assign w_shift = {r_rxd2, r_rxData[pFrameBits-1:pBitsParallel]};
        end else begin : g_shiftSingle
            assign w_shift = r_rxd2;
        end
    endgenerate

    // Shift register that accumulates the beats of the frame in progress.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rxData <= '0;
        end else if (w_beat) begin
            r_rxData <= w_shift;
        end
    end

    // Beat counter: restarts at the beat after an early sync, wraps after
    // the last beat of a frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (w_syncErr) begin
            r_cnt <= cAfterSync;
        end else if (w_beat) begin
            if (r_cnt == cLastBeat) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Bus qualifiers; an access acts only on its first clock (ack still low).
    assign w_cs          = cs_i & cyc_i & stb_i;
    assign w_firstClk    = w_cs & ~r_ack;
    assign w_dataRead    = w_firstClk & ~we_i & ~adr_i;
    assign w_statusWrite = w_firstClk & we_i & adr_i;

    // FIFO control. Fullness is judged before any same-cycle pop, so a
    // frame completing against a full FIFO is dropped even while a pop
    // frees an entry.
    assign w_full  = (r_count == cFullCount);
    assign w_empty = (r_count == '0);
    assign w_push  = w_frameDone & ~w_full;
    assign w_pop   = w_dataRead & ~w_empty & ~clear;
    assign w_head  = w_empty ? '0 : r_mem[r_rdPtr];

    // Storage array; no reset needed because the count masks stale entries.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_shift;
        end
    end

    // Pointer and occupancy bookkeeping; depth is a power of two so the
    // pointers wrap on their own.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Flag set and software-clear terms.
    assign w_overrunSet = w_frameDone & w_full;
    assign w_overrunClr = w_statusWrite & dat_i[0];
    assign w_frmerrClr  = w_statusWrite & dat_i[1];

    // Sticky overrun: a drop in the same clock wins over a software clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overrun <= 1'b0;
        end else if (clear) begin
            r_overrun <= 1'b0;
        end else if (w_overrunSet) begin
            r_overrun <= 1'b1;
        end else if (w_overrunClr) begin
            r_overrun <= 1'b0;
        end
    end

    // Sticky framing error: an early sync in the same clock wins over a clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_frmerr <= 1'b0;
        end else if (clear) begin
            r_frmerr <= 1'b0;
        end else if (w_syncErr) begin
            r_frmerr <= 1'b1;
        end else if (w_frmerrClr) begin
            r_frmerr <= 1'b0;
        end
    end

    // Acknowledge follows the qualified select one clock later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= w_cs;
        end
    end

    // Status word: flags in the top nibble, occupancy in the low byte.
    assign w_cnt8       = 8'(r_count);
    assign w_status32   = {r_frmerr, r_overrun, w_full, w_empty, 20'd0, w_cnt8};
    assign w_statusWide = pFrameBits'(w_status32);

    // Only the two flag-clear bits of the write data are meaningful.
    assign w_unusedBits = ^dat_i[31:2];

    // Read data mux; the bus is quiet (zero) outside a read and during reset.
    always_comb begin
        dat_o = '0;
        if (!rst_i && w_cs && !we_i) begin
            dat_o = adr_i ? w_statusWide : w_head;
        end
    end

    assign ack_o     = r_ack;
    assign overrun   = r_overrun;
    assign frmerr    = r_frmerr;
    assign fifofull  = w_full;
    assign fifoempty = w_empty;
    assign fifocnt   = r_count;
    assign irq_o     = ~w_empty | r_overrun | r_frmerr;

endmodule
